regfile_wb_arbiter: RTL

//   Shares the register bank's single write port among NUM_REQ writeback requesters (ALU, load unit, ...).

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter that shares the register bank's single write port among
// NUM_REQ writeback requesters. It also keeps a per-register pending-write
// scoreboard so that decode can stall on RAW hazards.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    input  logic                        rsv_valid,
    input  logic [ADDR_W-1:0]           rsv_addr,
    input  logic [ADDR_W-1:0]           qry_addr_1,
    input  logic [ADDR_W-1:0]           qry_addr_2,
    output logic                        qry_busy_1,
    output logic                        qry_busy_2
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    // Per-requester views of the flattened address/data buses
    logic [ADDR_W-1:0]  w_req_addr [NUM_REQ];
    logic [DATA_W-1:0]  w_req_data [NUM_REQ];

    // Arbitration results
    logic               w_grant_vld;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [ADDR_W-1:0]  w_grant_addr;
    logic [DATA_W-1:0]  w_grant_data;
    logic               w_wr_fire;

    // State
    logic [IDX_W-1:0]   r_last;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [DEPTH-1:0]   r_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_req_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin scan starting just after the last winner, wrapping around
    always_comb begin
        int idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_last) + 1 + k) % NUM_REQ;
            if (!w_grant_vld && req_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(idx);
            end
        end
    end

    // One-hot ready for the winner, zero when nobody is requesting
    always_comb begin
        req_ready = '0;
        if (w_grant_vld) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_grant_addr = w_req_addr[w_grant_idx];
    assign w_grant_data = w_req_data[w_grant_idx];

    // A granted write to r0 completes the handshake but never reaches the bank
    assign w_wr_fire = w_grant_vld && (w_grant_addr != '0);

    // Round-robin pointer: remember the most recent winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_grant_vld) begin
            r_last <= w_grant_idx;
        end
    end

    // Registered bank write port; address/data hold when no write is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= w_grant_addr;
                r_wr_data <= w_grant_data;
            end
        end
    end

    // Scoreboard: clear on grant, then set on reservation so a newer
    // reservation of the same register wins over the retiring write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_grant_vld) begin
                r_busy[w_grant_addr] <= 1'b0;
            end
            if (rsv_valid && (rsv_addr != '0)) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

    // r0 is hard-wired to zero, so it is never reported as pending
    assign qry_busy_1 = (qry_addr_1 != '0) && r_busy[qry_addr_1];
    assign qry_busy_2 = (qry_addr_2 != '0) && r_busy[qry_addr_2];

endmodule
